atm_ledger_arbiter: RTL and testbench
=====================================

Name: atm_ledger_arbiter

Overview:
- Shares one account-balance ledger between N_TERM ATM session controllers.
- Each session controller raises a request in its transaction states (deposit, withdraw, balance inquiry).
- The block grants requesters round-robin, executes one read-modify-write on the ledger per grant, and returns the updated balance plus a status code.
- It sits between the per-terminal session FSMs and the ledger storage it owns.

Parameters:
- N_TERM, 4, number of requesting terminals.
- AW, 2, account index width; the ledger holds 2^AW accounts.
- DW, 16, balance and amount width, unsigned.
- INIT_BAL, 100, balance loaded into every account at reset.

Ports:
- clk  in  1  rising-edge clock.
- CNL_n  in  1  asynchronous active-low reset.
- req  in  N_TERM  per-terminal request, level.
- op  in  2*N_TERM  per-terminal opcode, terminal i at bits [2i+1:2i]. 00 inquiry, 01 deposit, 10 withdraw, 11 illegal.
- acct  in  AW*N_TERM  per-terminal account index.
- amount  in  DW*N_TERM  per-terminal amount.
- gnt  out  N_TERM  one-hot grant, registered.
- done  out  1  one-cycle completion pulse for the granted terminal.
- status  out  2  valid with done. 00 OK, 01 insufficient funds, 10 overflow, 11 illegal op.
- result  out  DW  balance after the operation, valid with done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock, asynchronous active-low reset. All state updates on posedge clk.
- Reset (CNL_n=0, any time, including mid-transaction):
  - FSM to IDLE; gnt=0, done=0, status=00, result=0, busy=0.
  - Every ledger entry = INIT_BAL.
  - Round-robin pointer = N_TERM-1, so terminal 0 wins first.
- FSM: IDLE -> GRANT -> EXEC -> RESP -> IDLE. No other states; unused encodings go to IDLE.
- IDLE:
  - If any req bit is set, select the winner by round-robin starting at pointer+1 (mod N_TERM).
  - Next cycle: GRANT, gnt=onehot(winner), pointer=winner, busy=1.
  - If req=0, stay in IDLE.
- GRANT: latch op, acct and amount of the winner into internal registers; go to EXEC. Inputs are not sampled after this cycle.
- EXEC: read balance B=ledger[acct] and compute:
  - inquiry: result=B, status 00.
  - deposit: if B+amount > 2^DW-1, status 10 and ledger unchanged; else ledger=B+amount, status 00. The sum is computed at DW+1 bits.
  - withdraw: if amount > B, status 01 and ledger unchanged; else ledger=B-amount, status 00. amount==B is legal and gives 0.
  - op 11: status 11, ledger unchanged.
  - result = ledger value after the operation (unchanged B on any error).
- RESP: done=1 for exactly one cycle, with status and result stable. gnt stays held through RESP and clears on entry to IDLE.
- status and result hold their values until the next RESP.
- Latency: req sampled high in IDLE at edge k gives gnt at k+1, done at k+3. Back-to-back transactions take 4 cycles each.
- Handshake:
  - A requester holds req, op, acct and amount stable until its gnt is seen.
  - It drops req in the cycle after done, or the request counts as a new transaction.
  - If req drops after GRANT, the transaction still completes.
- Simultaneous requests: only one is granted per transaction. Losers keep req high and are served in round-robin order. With all N_TERM requesting continuously, each terminal is served once every N_TERM transactions (no starvation).
- Two terminals targeting the same account are serialised by construction. The second one sees the first one's update.
- Ledger writes happen only in EXEC. No read/write hazard exists because only one transaction is in flight.

Test Plan:
- Reset, then terminal 0 inquiry on acct 2 -> gnt=0001 at k+1, done at k+3, result=100, status=00, busy low after RESP.
- Terminal 1 withdraw 30 on acct 1, then inquiry on acct 1 -> result 70/00, then 70/00. Withdraw 71 -> status 01, result 70. Withdraw 70 -> result 0, status 00.
- Deposit 65435 on acct 3 (100+65435=65535) -> status 00, result 65535. Deposit 1 -> status 10, result 65535, ledger unchanged.
- All four terminals request simultaneously and hold req -> grant order 0,1,2,3,0 with done every 4 cycles. Terminal 3 deposits 10 then terminal 0 inquires the same account -> sees the updated value.
- Assert CNL_n low during EXEC of a deposit -> outputs zero immediately, the ledger entry reads 100 after release, and the next grant goes to terminal 0.
- op=11 from terminal 2 -> status 11, result = current balance, ledger unchanged. Dropping req after gnt still produces done.

Source files
------------

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter that gives N_TERM ATM session controllers access to a shared
// account ledger and runs one read-modify-write transaction per grant.
module atm_ledger_arbiter #(
  parameter int          N_TERM   = 4,
  parameter int          AW       = 2,
  parameter int          DW       = 16,
  parameter int unsigned INIT_BAL = 100
) (
  input  logic                 clk,
  input  logic                 CNL_n,
  input  logic [N_TERM-1:0]    req,
  input  logic [2*N_TERM-1:0]  op,
  input  logic [AW*N_TERM-1:0] acct,
  input  logic [DW*N_TERM-1:0] amount,
  output logic [N_TERM-1:0]    gnt,
  output logic                 done,
  output logic [1:0]           status,
  output logic [DW-1:0]        result,
  output logic                 busy
);

  localparam int PW     = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int N_ACCT = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {OP_INQ, OP_DEP, OP_WDR, OP_ILL} op_t;
  typedef enum logic [1:0] {ST_OK, ST_NSF, ST_OVF, ST_ILL} status_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr;
  logic [N_TERM-1:0] r_gnt;
  op_t             r_op;
  logic [AW-1:0]   r_acct;
  logic [DW-1:0]   r_amt;
  status_t         r_status;
  logic [DW-1:0]   r_result;
  logic [DW-1:0]   r_ledger [N_ACCT];

  logic            w_any;
  logic [PW-1:0]   w_winner;
  int              w_idx;
  logic [DW-1:0]   w_bal;
  logic [DW:0]     w_sum;
  logic [DW-1:0]   w_new;
  logic            w_wr;
  status_t         w_status;

  // Search from pointer+N down to pointer+1 so the nearest requester after the pointer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_idx    = 0;
    for (int k = N_TERM; k >= 1; k--) begin
      w_idx = (int'(r_ptr) + k) % N_TERM;
      if (req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge CNL_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!CNL_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_GRANT : S_IDLE;
      S_GRANT: w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == S_RESP);
    busy = (r_state != S_IDLE);
  end

  assign gnt    = r_gnt;
  assign status = r_status;
  assign result = r_result;

  // Transaction arithmetic; the deposit sum carries one extra bit to expose overflow.
  always_comb begin
    w_bal    = r_ledger[r_acct];
    w_sum    = {1'b0, w_bal} + {1'b0, r_amt};
    w_new    = w_bal;
    w_wr     = 1'b0;
    w_status = ST_OK;
    case (r_op)
      OP_INQ: w_status = ST_OK;
      OP_DEP: begin
        if (w_sum[DW]) begin
          w_status = ST_OVF;
        end else begin
          w_new = w_sum[DW-1:0];
          w_wr  = 1'b1;
        end
      end
      OP_WDR: begin
        if (r_amt > w_bal) begin
          w_status = ST_NSF;
        end else begin
          w_new = w_bal - r_amt;
          w_wr  = 1'b1;
        end
      end
      default: w_status = ST_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge CNL_n) begin
    if (!CNL_n) begin
      r_gnt    <= '0;
      r_ptr    <= PW'(N_TERM - 1);
      r_op     <= OP_INQ;
      r_acct   <= '0;
      r_amt    <= '0;
      r_status <= ST_OK;
      r_result <= '0;
      // NOTE: the ledger is small and must restart at a known balance, so it is reset like any register.
      for (int i = 0; i < N_ACCT; i++) r_ledger[i] <= DW'(INIT_BAL);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt <= N_TERM'(1) << w_winner;
            r_ptr <= w_winner;
          end
        end
        S_GRANT: begin
          r_op   <= op_t'(op[int'(r_ptr)*2 +: 2]);
          r_acct <= acct[int'(r_ptr)*AW +: AW];
          r_amt  <= amount[int'(r_ptr)*DW +: DW];
        end
        S_EXEC: begin
          r_status <= w_status;
          r_result <= w_new;
          if (w_wr) r_ledger[r_acct] <= w_new;
        end
        S_RESP: r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench for atm_ledger_arbiter: directed scenarios followed by random
// traffic, all compared against a balance/round-robin model kept in the bench.
module tb_atm_ledger_arbiter;

  localparam int N = 4;
  localparam logic [1:0] INQ = 2'd0, DEP = 2'd1, WDR = 2'd2, ILL = 2'd3;

  logic          clk = 1'b0;
  logic          CNL_n;
  logic [N-1:0]  req;
  logic [2*N-1:0]  op;
  logic [2*N-1:0]  acct;
  logic [16*N-1:0] amount;
  logic [N-1:0]  gnt;
  logic          done;
  logic [1:0]    status;
  logic [15:0]   result;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  int m_bal [4];
  int m_ptr;

  atm_ledger_arbiter #(.N_TERM(N), .AW(2), .DW(16), .INIT_BAL(100)) dut (
    .clk(clk), .CNL_n(CNL_n), .req(req), .op(op), .acct(acct), .amount(amount),
    .gnt(gnt), .done(done), .status(status), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bal[i] = 100;
    m_ptr = N - 1;
  endtask

  task automatic set_term(input int i, input logic [1:0] o, input logic [1:0] a, input int m);
    op[2*i +: 2]      = o;
    acct[2*i +: 2]    = a;
    amount[16*i +: 16] = 16'(m);
  endtask

  // Entered at a negedge with the DUT idle and req driven; leaves at the idle negedge after RESP.
  task automatic run_txn(input bit drop_after_gnt, input bit keep_req);
    int w, o, a, amt, b, e_res;
    logic [1:0] e_st;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w < 0) begin
      check("no_requester", 32'd1, 32'd0);
      return;
    end
    o   = int'(op[2*w +: 2]);
    a   = int'(acct[2*w +: 2]);
    amt = int'(amount[16*w +: 16]);
    b   = m_bal[a];
    e_st = 2'd0;
    case (o)
      0: e_st = 2'd0;
      1: if (b + amt > 65535) e_st = 2'd2; else b = b + amt;
      2: if (amt > b) e_st = 2'd1; else b = b - amt;
      default: e_st = 2'd3;
    endcase
    e_res = b;

    @(negedge clk);
    check("gnt_grant", gnt, 32'(1) << w);
    check("busy_grant", busy, 1);
    check("done_grant", done, 0);
    if (drop_after_gnt) req[w] = 1'b0;
    @(negedge clk);
    check("done_exec", done, 0);
    @(negedge clk);
    check("done_resp", done, 1);
    check("status_resp", status, e_st);
    check("result_resp", result, e_res);
    check("gnt_resp", gnt, 32'(1) << w);
    m_bal[a] = b;
    m_ptr    = w;
    if (!keep_req) req[w] = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("gnt_idle", gnt, 0);
    check("done_idle", done, 0);
    check("status_hold", status, e_st);
    check("result_hold", result, e_res);
  endtask

  initial begin
    CNL_n = 1'b1;
    req = '0; op = '0; acct = '0; amount = '0;
    model_reset();
    #1 CNL_n = 1'b0;
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    CNL_n = 1'b1;

    // Terminal 0 inquiry on fresh account
    set_term(0, INQ, 2'd2, 0); req = 4'b0001; run_txn(0, 0);

    // Withdraw sequence on account 1 from terminal 1
    set_term(1, WDR, 2'd1, 30); req = 4'b0010; run_txn(0, 0);
    set_term(1, INQ, 2'd1, 0);  req = 4'b0010; run_txn(0, 0);
    set_term(1, WDR, 2'd1, 71); req = 4'b0010; run_txn(0, 0);
    set_term(1, WDR, 2'd1, 70); req = 4'b0010; run_txn(0, 0);

    // Deposit to the top of the range, then one past it
    set_term(3, DEP, 2'd3, 65435); req = 4'b1000; run_txn(0, 0);
    set_term(3, DEP, 2'd3, 1);     req = 4'b1000; run_txn(0, 0);
    set_term(3, INQ, 2'd3, 0);     req = 4'b1000; run_txn(0, 0);

    // All four hold req: order 0,1,2,3,0 and terminal 0 sees terminal 3's deposit
    set_term(0, INQ, 2'd0, 0);
    set_term(1, INQ, 2'd0, 0);
    set_term(2, INQ, 2'd0, 0);
    set_term(3, DEP, 2'd0, 10);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) run_txn(0, 1);
    req = 4'b0000;
    @(negedge clk);

    // Reset in the middle of a deposit
    set_term(1, DEP, 2'd2, 50); req = 4'b0010;
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0010);
    @(negedge clk);
    CNL_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_status", status, 0);
    check("mid_rst_result", result, 0);
    req = '0;
    model_reset();
    @(negedge clk);
    CNL_n = 1'b1;
    set_term(0, INQ, 2'd1, 0);
    set_term(2, INQ, 2'd2, 0);
    req = 4'b0101;
    run_txn(0, 0);
    run_txn(0, 0);

    // Illegal opcode with req dropped right after the grant
    set_term(2, ILL, 2'd1, 5); req = 4'b0100; run_txn(1, 0);
    set_term(2, INQ, 2'd1, 0); req = 4'b0100; run_txn(0, 0);

    // Random traffic; losers keep their request pending until served
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          int a, m;
          a = int'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0: m = int'($urandom_range(0, 150));
            1: m = m_bal[a];
            2: m = (m_bal[a] + 1) % 65536;
            default: m = 65535 - m_bal[a] + int'($urandom_range(0, 1));
          endcase
          set_term(i, 2'($urandom_range(0, 3)), 2'(a), m);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        set_term(0, DEP, 2'($urandom_range(0, 3)), int'($urandom_range(0, 500)));
        req[0] = 1'b1;
      end
      run_txn(0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
